// File: rtl/noc_params.sv
// Shared NoC parameters and flit format used by the router buffers.
package noc_params;
    localparam int VC_NUM    = 4;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int DATA_SIZE = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        logic [DATA_SIZE-1:0] data;
    } flit_t;
endpackage

// File: rtl/vc_queue.sv
// One virtual-channel ring buffer with occupancy, on/off hysteresis and sticky error flags.
module vc_queue
    import noc_params::*;
#(
    parameter int BUFFER_SIZE    = 8,
    parameter int PIPELINE_DEPTH = 5,
    parameter int ON_THRESHOLD   = BUFFER_SIZE - PIPELINE_DEPTH - 1
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data,
    input  logic  write,
    input  logic  read,
    output flit_t head,
    output logic  is_full,
    output logic  is_empty,
    output logic  on_off,
    output logic  overflow,
    output logic  underflow
);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0] OFF_LVL  = CW'(BUFFER_SIZE - PIPELINE_DEPTH);
    localparam logic [CW-1:0] ON_LVL   = CW'(ON_THRESHOLD);

    flit_t          mem [BUFFER_SIZE];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_next;
    logic           do_read, do_write;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_LVL);
    // A full queue still accepts a write when its head is popped in the same cycle.
    assign do_read  = read & ~is_empty;
    assign do_write = write & (~is_full | do_read);
    assign head     = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_write && !do_read)
            count_next = count + CW'(1);
        else if (!do_write && do_read)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            on_off    <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (do_read)  rd_ptr <= rd_ptr + PW'(1);
            if (do_write) wr_ptr <= wr_ptr + PW'(1);
            if (write && !do_write) overflow  <= 1'b1;
            if (read && is_empty)   underflow <= 1'b1;
            // Drop early enough to absorb the flits already in the upstream pipeline.
            if (count_next >= OFF_LVL)
                on_off <= 1'b0;
            else if (count_next <= ON_LVL)
                on_off <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= data;
    end
endmodule

// File: rtl/vc_circular_buffer.sv
// Per-VC input buffer: steers writes/reads to VC_NUM ring queues and muxes the selected head.
module vc_circular_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE    = 8,
    parameter int PIPELINE_DEPTH = 5,
    parameter int ON_THRESHOLD   = BUFFER_SIZE - PIPELINE_DEPTH - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              data_i,
    input  logic               write_i,
    input  logic               read_i,
    input  logic [VC_SIZE-1:0] read_vc_i,
    output flit_t              data_o,
    output logic [VC_NUM-1:0]  is_full_o,
    output logic [VC_NUM-1:0]  is_empty_o,
    output logic [VC_NUM-1:0]  on_off_o,
    output logic [VC_NUM-1:0]  overflow_o,
    output logic [VC_NUM-1:0]  underflow_o
);
    flit_t head [VC_NUM];

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic write_v, read_v;
        assign write_v = write_i && (data_i.vc_id == VC_SIZE'(v));
        assign read_v  = read_i && (read_vc_i == VC_SIZE'(v));

        vc_queue #(
            .BUFFER_SIZE   (BUFFER_SIZE),
            .PIPELINE_DEPTH(PIPELINE_DEPTH),
            .ON_THRESHOLD  (ON_THRESHOLD)
        ) u_queue (
            .clk      (clk),
            .rst      (rst),
            .data     (data_i),
            .write    (write_v),
            .read     (read_v),
            .head     (head[v]),
            .is_full  (is_full_o[v]),
            .is_empty (is_empty_o[v]),
            .on_off   (on_off_o[v]),
            .overflow (overflow_o[v]),
            .underflow(underflow_o[v])
        );
    end

    assign data_o = head[read_vc_i];
endmodule
